// File: rtl/sync_fifo_wr_arb.sv
// Round-robin write arbiter feeding a single sync_fifo write port, with credit-based overflow protection.
// Optional packet lock (i_last honoured) when SYNC_FIFO_ARB_LOCK_EN is defined.
module sync_fifo_wr_arb #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 19,
    parameter int DEPTH = 128
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [N_REQ-1:0]             i_valid,
    input  logic [N_REQ*WIDTH-1:0]       i_data,
    input  logic [N_REQ-1:0]             i_last,
    output logic [N_REQ-1:0]             o_ready,
    output logic [WIDTH-1:0]             o_fifo_data,
    output logic                         o_fifo_wr_en,
    input  logic                         i_fifo_pop,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_pop_err
);
    localparam int PW = $clog2(N_REQ);
    localparam int LW = $clog2(DEPTH+1);

    logic [PW-1:0]    r_ptr;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_data;
    logic             r_wr_en;
    logic             r_pop_err;

    logic [N_REQ-1:0] w_mask;
    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_grant;
    logic [PW-1:0]    w_win_idx;
    logic [WIDTH-1:0] w_win_data;
    logic             w_found;
    logic             w_has_credit;
    logic             w_accept;
    logic             w_pop_ok;

`ifdef SYNC_FIFO_ARB_LOCK_EN
    logic          r_locked;
    logic [PW-1:0] r_owner;

    // Lock follows the last accepted word: a non-last word pins the owner.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_locked <= 1'b0;
            r_owner  <= '0;
        end else if (w_accept) begin
            r_locked <= ~i_last[w_win_idx];
            r_owner  <= w_win_idx;
        end
    end

    assign w_mask = r_locked ? (N_REQ'(1) << r_owner) : '1;
`else
    logic w_unused_last;
    assign w_unused_last = ^i_last;
    assign w_mask        = '1;
`endif

    // Credits are implicit: DEPTH - r_level.
    assign w_has_credit = (r_level != LW'(DEPTH));
    assign w_elig       = i_valid & w_mask & {N_REQ{w_has_credit}};

    always_comb begin
        w_grant    = '0;
        w_win_idx  = '0;
        w_win_data = '0;
        w_found    = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            int j;
            j = int'(r_ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!w_found && w_elig[j]) begin
                w_found    = 1'b1;
                w_grant[j] = 1'b1;
                w_win_idx  = PW'(j);
                w_win_data = i_data[j*WIDTH +: WIDTH];
            end
        end
    end

    assign o_ready  = i_rst_n ? w_grant : '0;
    assign w_accept = |o_ready;
    assign w_pop_ok = i_fifo_pop && (r_level != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr     <= PW'(N_REQ-1);
            r_level   <= '0;
            r_data    <= '0;
            r_wr_en   <= 1'b0;
            r_pop_err <= 1'b0;
        end else begin
            r_wr_en   <= w_accept;
            r_pop_err <= i_fifo_pop && (r_level == '0);
            if (w_accept) begin
                r_data <= w_win_data;
                r_ptr  <= w_win_idx;
            end
            // A pop against an empty FIFO is flagged and otherwise ignored.
            case ({w_accept, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_fifo_data  = r_data;
    assign o_fifo_wr_en = r_wr_en;
    assign o_level      = r_level;
    assign o_pop_err    = r_pop_err;
endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Self-checking bench for sync_fifo_wr_arb: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level reference model.
module tb_sync_fifo_wr_arb;
    localparam int N  = 4;
    localparam int W  = 19;
    localparam int D  = 128;
    localparam int LW = $clog2(D+1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     valid;
    logic [N*W-1:0]   data;
    logic [N-1:0]     last;
    logic [N-1:0]     ready;
    logic [W-1:0]     fifo_data;
    logic             fifo_wr_en;
    logic             pop;
    logic [LW-1:0]    level;
    logic             pop_err;

    always #5 clk = ~clk;

    sync_fifo_wr_arb #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .i_last(last),
        .o_ready(ready), .o_fifo_data(fifo_data), .o_fifo_wr_en(fifo_wr_en),
        .i_fifo_pop(pop), .o_level(level), .o_pop_err(pop_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int         m_level  = 0;
    int         m_ptr    = N-1;
    bit         m_locked = 0;
    int         m_owner  = 0;
    bit         m_wr     = 0;
    bit [W-1:0] m_data   = '0;
    bit         m_err    = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g = '0;
        if (rst_n && (D - m_level) > 0) begin
            for (int d = 1; d <= N; d++) begin
                int k = (m_ptr + d) % N;
                if (valid[k] && (!m_locked || k == m_owner)) begin
                    g[k] = 1'b1;
                    return g;
                end
            end
        end
        return g;
    endfunction

    // One clock: apply inputs just after negedge, check ready, advance model, check registered outputs.
    task automatic cycle(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                         input logic p, output logic [N-1:0] obs);
        logic [N-1:0] g;
        int           k;
        rst_n = r; valid = v; last = l; pop = p;
        for (int i = 0; i < N; i++) data[i*W +: W] = W'($urandom);
        #1;
        g   = model_grant();
        obs = ready;
        chk("ready", 32'(ready), 32'(g));
        @(posedge clk);
        if (!r) begin
            m_level = 0; m_ptr = N-1; m_locked = 0; m_owner = 0;
            m_wr = 0; m_data = '0; m_err = 0;
        end else begin
            m_wr  = (g != 0);
            m_err = p && (m_level == 0);
            if (g != 0) begin
                k      = $clog2(g);
                m_data = data[k*W +: W];
                m_ptr  = k;
`ifdef SYNC_FIFO_ARB_LOCK_EN
                m_locked = !l[k];
                m_owner  = k;
`endif
            end
            m_level = m_level + ((g != 0) ? 1 : 0) - ((p && m_level > 0) ? 1 : 0);
        end
        @(negedge clk);
        chk("wr_en", 32'(fifo_wr_en), 32'(m_wr));
        if (m_wr) chk("fifo_data", 32'(fifo_data), 32'(m_data));
        chk("level", 32'(level), 32'(m_level));
        chk("pop_err", 32'(pop_err), 32'(m_err));
    endtask

    task automatic do_reset();
        logic [N-1:0] o;
        cycle(1'b0, '0, '1, 1'b0, o);
    endtask

    initial begin
        logic [N-1:0] o;
        logic [N-1:0] exp_seq [6];
        int           n1;

        rst_n = 1'b0; valid = '0; data = '0; last = '1; pop = 1'b0;
        @(negedge clk);

        // reset held with all requesters valid, then rotating grants from requester 0
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 4'b1111, 4'b1111, 1'b0, o);
            chk("rst_ready", 32'(o), 32'h0);
            chk("rst_level", 32'(level), 32'h0);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 4'b1111, 4'b1111, 1'b0, o);
            chk("rr_order", 32'(o), 32'(1 << (i % 4)));
        end

        // fill to capacity from one requester, then one pop frees exactly one slot
        do_reset();
        for (int i = 0; i < D; i++) cycle(1'b1, 4'b0100, 4'b1111, 1'b0, o);
        chk("full_level", 32'(level), 32'(D));
        cycle(1'b1, 4'b0100, 4'b1111, 1'b0, o);
        chk("full_block", 32'(o), 32'h0);
        cycle(1'b1, 4'b0100, 4'b1111, 1'b1, o);
        chk("pop_same_cyc", 32'(o), 32'h0);
        chk("level_after_pop", 32'(level), 32'(D-1));
        cycle(1'b1, 4'b0100, 4'b1111, 1'b0, o);
        chk("refill", 32'(o), 32'b0100);
        chk("level_refill", 32'(level), 32'(D));
        cycle(1'b1, 4'b0100, 4'b1111, 1'b0, o);
        chk("full_again", 32'(o), 32'h0);

        // accept and pop together at mid level
        do_reset();
        for (int i = 0; i < 64; i++) cycle(1'b1, 4'b0001, 4'b1111, 1'b0, o);
        cycle(1'b1, 4'b0001, 4'b1111, 1'b1, o);
        chk("mid_acc_pop", 32'(level), 32'd64);

        // pop against empty
        do_reset();
        cycle(1'b1, 4'b0000, 4'b1111, 1'b1, o);
        chk("pop_err_set", 32'(pop_err), 32'h1);
        chk("pop_err_lvl", 32'(level), 32'h0);
        cycle(1'b1, 4'b0000, 4'b1111, 1'b0, o);
        chk("pop_err_clr", 32'(pop_err), 32'h0);

        // packet from requester 1 competing with 0 and 3
        do_reset();
        cycle(1'b1, 4'b0001, 4'b1111, 1'b0, o);
`ifdef SYNC_FIFO_ARB_LOCK_EN
        exp_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
`else
        exp_seq = '{4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001};
`endif
        n1 = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 4'b1011, {2'b11, (n1 == 3), 1'b1}, 1'b0, o);
            chk("pkt_grant", 32'(o), 32'(exp_seq[i]));
            if (o == 4'b0010) n1++;
        end

        // reset in the middle of a stream
        do_reset();
        for (int i = 0; i < 50; i++) cycle(1'b1, 4'b1111, 4'b1111, 1'b0, o);
        chk("pre_rst_lvl", 32'(level), 32'd50);
        cycle(1'b0, 4'b1111, 4'b1111, 1'b0, o);
        chk("rst_mid_ready", 32'(o), 32'h0);
        chk("rst_mid_wr", 32'(fifo_wr_en), 32'h0);
        chk("rst_mid_lvl", 32'(level), 32'h0);
        cycle(1'b1, 4'b1111, 4'b1111, 1'b0, o);
        chk("rst_mid_rr", 32'(o), 32'b0001);

        // randomized traffic at several pop rates
        foreach (exp_seq[ph]) begin
            int pct;
            if (ph >= 3) break;
            pct = (ph == 0) ? 10 : (ph == 1) ? 50 : 90;
            for (int i = 0; i < 600; i++) begin
                logic r;
                r = ($urandom_range(0, 299) != 0);
                cycle(r, N'($urandom), N'($urandom | $urandom),
                      ($urandom_range(0, 99) < pct), o);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
